// File: rtl/m_axil_master.sv
// Single-outstanding AXI4-Lite master: turns one command on the cmd port into one
// AXI-Lite read or write and hands the slave's answer back on the rsp port.
`timescale 1ns/1ps
module m_axil_master #(
  parameter int M_AXI_ADDR_WIDTH = 6,
  parameter int M_AXI_DATA_WIDTH = 32
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                    rsp_resp,
  output logic [M_AXI_ADDR_WIDTH-1:0]   AWADDR,
  output logic                          AWVALID,
  input  logic                          AWREADY,
  output logic [M_AXI_DATA_WIDTH-1:0]   WDATA,
  output logic [M_AXI_DATA_WIDTH/8-1:0] WSTRB,
  output logic                          WVALID,
  input  logic                          WREADY,
  input  logic [1:0]                    BRESP,
  input  logic                          BVALID,
  output logic                          BREADY,
  output logic [M_AXI_ADDR_WIDTH-1:0]   ARADDR,
  output logic                          ARVALID,
  input  logic                          ARREADY,
  input  logic [M_AXI_DATA_WIDTH-1:0]   RDATA,
  input  logic [1:0]                    RRESP,
  input  logic                          RVALID,
  output logic                          RREADY
);

  localparam int STRB_WIDTH = M_AXI_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_DATA,
    RSP
  } state_t;

  state_t                        state_reg, state_next;
  logic                          awvalid_reg, awvalid_next;
  logic                          wvalid_reg, wvalid_next;
  logic                          arvalid_reg, arvalid_next;
  logic [M_AXI_ADDR_WIDTH-1:0]   awaddr_reg, awaddr_next;
  logic [M_AXI_ADDR_WIDTH-1:0]   araddr_reg, araddr_next;
  logic [M_AXI_DATA_WIDTH-1:0]   wdata_reg, wdata_next;
  logic [STRB_WIDTH-1:0]         wstrb_reg, wstrb_next;
  logic [M_AXI_DATA_WIDTH-1:0]   rdata_reg, rdata_next;
  logic [1:0]                    resp_reg, resp_next;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_reg   <= IDLE;
      awvalid_reg <= 1'b0;
      wvalid_reg  <= 1'b0;
      arvalid_reg <= 1'b0;
      awaddr_reg  <= '0;
      araddr_reg  <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
      rdata_reg   <= '0;
      resp_reg    <= 2'b00;
    end else begin
      state_reg   <= state_next;
      awvalid_reg <= awvalid_next;
      wvalid_reg  <= wvalid_next;
      arvalid_reg <= arvalid_next;
      awaddr_reg  <= awaddr_next;
      araddr_reg  <= araddr_next;
      wdata_reg   <= wdata_next;
      wstrb_reg   <= wstrb_next;
      rdata_reg   <= rdata_next;
      resp_reg    <= resp_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    awvalid_next = awvalid_reg;
    wvalid_next  = wvalid_reg;
    arvalid_next = arvalid_reg;
    awaddr_next  = awaddr_reg;
    araddr_next  = araddr_reg;
    wdata_next   = wdata_reg;
    wstrb_next   = wstrb_reg;
    rdata_next   = rdata_reg;
    resp_next    = resp_reg;

    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_write) begin
            awaddr_next  = cmd_addr;
            wdata_next   = cmd_wdata;
            wstrb_next   = cmd_wstrb;
            awvalid_next = 1'b1;
            wvalid_next  = 1'b1;
            state_next   = WR_REQ;
          end else begin
            araddr_next  = cmd_addr;
            arvalid_next = 1'b1;
            state_next   = RD_REQ;
          end
        end
      end

      // AW and W complete independently; move on once neither is still pending.
      WR_REQ: begin
        if (awvalid_reg && AWREADY) awvalid_next = 1'b0;
        if (wvalid_reg && WREADY)   wvalid_next  = 1'b0;
        if (!awvalid_next && !wvalid_next) state_next = WR_RESP;
      end

      WR_RESP: begin
        if (BVALID) begin
          resp_next  = BRESP;
          rdata_next = '0;
          state_next = RSP;
        end
      end

      RD_REQ: begin
        if (ARREADY) begin
          arvalid_next = 1'b0;
          state_next   = RD_DATA;
        end
      end

      RD_DATA: begin
        if (RVALID) begin
          rdata_next = RDATA;
          resp_next  = RRESP;
          state_next = RSP;
        end
      end

      RSP: begin
        if (rsp_ready) state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  assign cmd_ready = (state_reg == IDLE);
  assign rsp_valid = (state_reg == RSP);
  assign BREADY    = (state_reg == WR_RESP);
  assign RREADY    = (state_reg == RD_DATA);
  assign AWVALID   = awvalid_reg;
  assign WVALID    = wvalid_reg;
  assign ARVALID   = arvalid_reg;
  assign AWADDR    = awaddr_reg;
  assign WDATA     = wdata_reg;
  assign WSTRB     = wstrb_reg;
  assign ARADDR    = araddr_reg;
  assign rsp_rdata = rdata_reg;
  assign rsp_resp  = resp_reg;

endmodule
